xmem_bus_ctrl: RTL and testbench

Sequencer for 8051 MOVX external data memory cycles.
- Multiplexes P2 pins between the P2 SFR value and the high address byte.
- Multiplexes P0 pins between the P0 SFR value, the low address byte and data.
- Generates ALE, RD_n and WR_n strobes.
- Sits between the CPU control unit (issues MOVX requests) and the port pin drivers; the P2/P0 SFR registers feed it their stored values.

---
 rtl/xmem_bus_ctrl_pkg.sv | 15 +
 rtl/xmem_bus_ctrl.sv | 116 +++++++++++
 tb/tb_xmem_bus_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xmem_bus_ctrl_pkg.sv
// Shared types and defaults for the 8051 MOVX external data memory sequencer.
package xmem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } xmemState_e;

  localparam int XMEM_STROBE_CYC = 2;
  localparam int XMEM_CNT_W      = 4;

endpackage

// File: rtl/xmem_bus_ctrl.sv
// MOVX bus sequencer: drives ALE/RD_n/WR_n and multiplexes P2/P0 between SFR
// values, the latched address and write data for one external memory cycle.
module xmem_bus_ctrl
  import xmem_bus_ctrl_pkg::*;
#(
  parameter int STROBE_CYC = XMEM_STROBE_CYC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic        i_dptr_mode,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic [7:0]  i_p2_sfr,
  input  logic [7:0]  i_p0_sfr,
  input  logic [7:0]  i_p0_in,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_rdata,
  output logic [7:0]  o_p2_pins,
  output logic [7:0]  o_p0_out,
  output logic        o_p0_oe,
  output logic        o_ale,
  output logic        o_rd_n,
  output logic        o_wr_n
);

  if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_badStrobeCyc
    $error("xmem_bus_ctrl: STROBE_CYC must be in 1..15");
  end

  localparam logic [XMEM_CNT_W-1:0] CNT_LOAD = XMEM_CNT_W'(STROBE_CYC - 1);

  xmemState_e            r_state;
  xmemState_e            w_nextState;
  logic [XMEM_CNT_W-1:0] r_strobeCnt;
  logic                  r_wr;
  logic [15:0]           r_addr;
  logic [7:0]            r_wdata;
  logic [7:0]            r_rdata;
  logic                  r_ale;
  logic                  r_rdN;
  logic                  r_wrN;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (i_req) w_nextState = ST_ADDR;
      ST_ADDR:   w_nextState = ST_LATCH;
      ST_LATCH:  w_nextState = ST_STROBE;
      ST_STROBE: if (r_strobeCnt == '0) w_nextState = ST_HOLD;
      ST_HOLD:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Strobes and ALE are registered from the next state so the pins never glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_strobeCnt <= '0;
      r_wr        <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_rdata     <= 8'h00;
      r_ale       <= 1'b0;
      r_rdN       <= 1'b1;
      r_wrN       <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && i_req) begin
        r_wr    <= i_wr;
        r_wdata <= i_wdata;
        r_addr  <= {(i_dptr_mode ? i_addr[15:8] : i_p2_sfr), i_addr[7:0]};
      end
      if (r_state != ST_STROBE && w_nextState == ST_STROBE) begin
        r_strobeCnt <= CNT_LOAD;
      end else if (r_state == ST_STROBE && r_strobeCnt != '0) begin
        r_strobeCnt <= r_strobeCnt - 1'b1;
      end
      if (r_state == ST_STROBE && r_strobeCnt == '0 && !r_wr) begin
        r_rdata <= i_p0_in;
      end
      r_ale <= (w_nextState == ST_ADDR);
      r_rdN <= !(w_nextState == ST_STROBE && !r_wr);
      r_wrN <= !(w_nextState == ST_STROBE && r_wr);
    end
  end

  // Outside IDLE the pins show the latched address; P0 turns to data or floats.
  always_comb begin
    o_p2_pins = r_addr[15:8];
    o_p0_out  = r_addr[7:0];
    o_p0_oe   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_p2_pins = i_p2_sfr;
        o_p0_out  = i_p0_sfr;
      end
      ST_STROBE, ST_HOLD: begin
        if (r_wr) o_p0_out = r_wdata;
        else      o_p0_oe  = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = (r_state == ST_HOLD);
  assign o_rdata = r_rdata;
  assign o_ale   = r_ale;
  assign o_rd_n  = r_rdN;
  assign o_wr_n  = r_wrN;

endmodule

// File: tb/tb_xmem_bus_ctrl.sv
// Bench for xmem_bus_ctrl: three instances (STROBE_CYC 2, 1, 15) share stimulus
// and are checked every cycle against a cycle-offset model of a MOVX transfer.
module tb_xmem_bus_ctrl;

  localparam int NDUT = 3;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic        dptrMode;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  p2Sfr;
  logic [7:0]  p0Sfr;
  logic [7:0]  p0In;

  logic        busy   [NDUT];
  logic        done   [NDUT];
  logic [7:0]  rdata  [NDUT];
  logic [7:0]  p2Pins [NDUT];
  logic [7:0]  p0Out  [NDUT];
  logic        p0Oe   [NDUT];
  logic        ale    [NDUT];
  logic        rdN    [NDUT];
  logic        wrN    [NDUT];

  int numCompared;
  int numMismatched;

  function automatic int strobeOf(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    xmem_bus_ctrl #(.STROBE_CYC((g == 0) ? 2 : ((g == 1) ? 1 : 15))) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_req      (req),
      .i_wr       (wr),
      .i_dptr_mode(dptrMode),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .i_p2_sfr   (p2Sfr),
      .i_p0_sfr   (p0Sfr),
      .i_p0_in    (p0In),
      .o_busy     (busy[g]),
      .o_done     (done[g]),
      .o_rdata    (rdata[g]),
      .o_p2_pins  (p2Pins[g]),
      .o_p0_out   (p0Out[g]),
      .o_p0_oe    (p0Oe[g]),
      .o_ale      (ale[g]),
      .o_rd_n     (rdN[g]),
      .o_wr_n     (wrN[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int inst, input int actual, input int expected);
    numCompared++;
    if (actual != expected) begin
      numMismatched++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, inst, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic reqV, input logic wrV, input logic dptrV,
                               input logic [15:0] addrV, input logic [7:0] wdataV,
                               input logic [7:0] p2V, input logic [7:0] p0SfrV,
                               input logic [7:0] p0InV);
    @(posedge clk);
    #2;
    req      = reqV;
    wr       = wrV;
    dptrMode = dptrV;
    addr     = addrV;
    wdata    = wdataV;
    p2Sfr    = p2V;
    p0Sfr    = p0SfrV;
    p0In     = p0InV;
  endtask

  // Model: mOff is the number of cycles since the accepting edge (0 = idle).
  // Offsets 1 and 2 are the address phases, 3..2+S the strobe, 3+S the hold.
  int          mOff  [NDUT];
  logic        mWr   [NDUT];
  logic [15:0] mAddr [NDUT];
  logic [7:0]  mWd   [NDUT];
  logic [7:0]  mRd   [NDUT];

  task automatic modelClear();
    for (int g = 0; g < NDUT; g++) begin
      mOff[g]  = 0;
      mWr[g]   = 1'b0;
      mAddr[g] = 16'h0000;
      mWd[g]   = 8'h00;
      mRd[g]   = 8'h00;
    end
  endtask

  initial begin
    modelClear();
    forever begin
      @(posedge clk);
      if (rst) begin
        modelClear();
      end else begin
        for (int g = 0; g < NDUT; g++) begin
          int s;
          s = strobeOf(g);
          if (mOff[g] == 0) begin
            if (req) begin
              mOff[g]  = 1;
              mWr[g]   = wr;
              mWd[g]   = wdata;
              mAddr[g] = {(dptrMode ? addr[15:8] : p2Sfr), addr[7:0]};
            end
          end else begin
            if (mOff[g] == 2 + s && !mWr[g]) mRd[g] = p0In;
            mOff[g] = (mOff[g] == 3 + s) ? 0 : mOff[g] + 1;
          end
        end
      end
      @(negedge clk);
      if (rst) modelClear();
      for (int g = 0; g < NDUT; g++) begin
        int   s;
        int   off;
        logic inStrobe;
        s        = strobeOf(g);
        off      = mOff[g];
        inStrobe = (off >= 3) && (off <= 2 + s);
        checkOutput("busy",  g, int'(busy[g]),  int'(off != 0));
        checkOutput("done",  g, int'(done[g]),  int'(off == 3 + s));
        checkOutput("ale",   g, int'(ale[g]),   int'(off == 1));
        checkOutput("rdN",   g, int'(rdN[g]),   int'(!(inStrobe && !mWr[g])));
        checkOutput("wrN",   g, int'(wrN[g]),   int'(!(inStrobe && mWr[g])));
        checkOutput("rdata", g, int'(rdata[g]), int'(mRd[g]));
        checkOutput("p2",    g, int'(p2Pins[g]), (off == 0) ? int'(p2Sfr) : int'(mAddr[g][15:8]));
        if (off == 0) begin
          checkOutput("p0",   g, int'(p0Out[g]), int'(p0Sfr));
          checkOutput("p0Oe", g, int'(p0Oe[g]), 1);
        end else if (off <= 2) begin
          checkOutput("p0",   g, int'(p0Out[g]), int'(mAddr[g][7:0]));
          checkOutput("p0Oe", g, int'(p0Oe[g]), 1);
        end else if (mWr[g]) begin
          checkOutput("p0",   g, int'(p0Out[g]), int'(mWd[g]));
          checkOutput("p0Oe", g, int'(p0Oe[g]), 1);
        end else begin
          checkOutput("p0Oe", g, int'(p0Oe[g]), 0);
        end
      end
    end
  end

  initial begin
    int expWidth   [NDUT];
    int expLatency [NDUT];
    int lowCnt     [NDUT];
    int doneAt     [NDUT];
    int doneCnt    [NDUT];
    int secondDone;
    int dut0Dones;

    expWidth   = '{2, 1, 15};
    expLatency = '{5, 4, 18};
    numCompared   = 0;
    numMismatched = 0;

    rst = 1'b0; req = 1'b0; wr = 1'b0; dptrMode = 1'b0; addr = 16'h0000;
    wdata = 8'h00; p2Sfr = 8'hA5; p0Sfr = 8'h3C; p0In = 8'h00;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput("rstP2",    g, int'(p2Pins[g]), 'hA5);
      checkOutput("rstP0",    g, int'(p0Out[g]),  'h3C);
      checkOutput("rstP0Oe",  g, int'(p0Oe[g]),   1);
      checkOutput("rstAle",   g, int'(ale[g]),    0);
      checkOutput("rstRdN",   g, int'(rdN[g]),    1);
      checkOutput("rstWrN",   g, int'(wrN[g]),    1);
      checkOutput("rstBusy",  g, int'(busy[g]),   0);
      checkOutput("rstDone",  g, int'(done[g]),   0);
      checkOutput("rstRdata", g, int'(rdata[g]),  'h00);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) applyStimulus(0, 0, 0, 16'h0000, 8'h00, 8'hA5, 8'h3C, 8'h00);

    $display("[TB] DPTR read of 0x12F0");
    applyStimulus(1, 0, 1, 16'h12F0, 8'h00, 8'hA5, 8'h3C, 8'h5A);
    for (int g = 0; g < NDUT; g++) begin lowCnt[g] = 0; doneAt[g] = 0; doneCnt[g] = 0; end
    for (int c = 1; c <= 25; c++) begin
      applyStimulus(0, 0, 1, 16'h12F0, 8'h00, 8'hA5, 8'h3C, 8'h5A);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (c == 1) begin
          checkOutput("readAddrAle", g, int'(ale[g]),    1);
          checkOutput("readAddrP2",  g, int'(p2Pins[g]), 'h12);
          checkOutput("readAddrP0",  g, int'(p0Out[g]),  'hF0);
        end
        if (c == 3) checkOutput("readStrobeOe", g, int'(p0Oe[g]), 0);
        if (!rdN[g]) lowCnt[g]++;
        if (done[g]) begin
          doneCnt[g]++;
          if (doneAt[g] == 0) doneAt[g] = c;
        end
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      checkOutput("readRdWidth",  g, lowCnt[g],  expWidth[g]);
      checkOutput("readLatency",  g, doneAt[g],  expLatency[g]);
      checkOutput("readDoneCnt",  g, doneCnt[g], 1);
      checkOutput("readRdata",    g, int'(rdata[g]),  'h5A);
      checkOutput("readIdleP2",   g, int'(p2Pins[g]), 'hA5);
    end

    $display("[TB] @Ri write of 0xC3 to 0x44 with P2 SFR 0x80");
    applyStimulus(1, 1, 0, 16'hBE44, 8'hC3, 8'h80, 8'h3C, 8'h5A);
    for (int g = 0; g < NDUT; g++) lowCnt[g] = 0;
    for (int c = 1; c <= 25; c++) begin
      applyStimulus(0, 1, 0, 16'hBE44, 8'hC3, (c >= 3) ? 8'h81 : 8'h80, 8'h3C, 8'h5A);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (c == 1) begin
          checkOutput("writeAddrP2", g, int'(p2Pins[g]), 'h80);
          checkOutput("writeAddrP0", g, int'(p0Out[g]),  'h44);
        end
        if (!wrN[g]) lowCnt[g]++;
      end
      if (c == 4) begin
        checkOutput("writeHeldP2", 0, int'(p2Pins[0]), 'h80);
        checkOutput("writeDataP0", 0, int'(p0Out[0]),  'hC3);
        checkOutput("writeWrN",    0, int'(wrN[0]),    0);
      end
    end
    for (int g = 0; g < NDUT; g++) begin
      checkOutput("writeWrWidth", g, lowCnt[g], expWidth[g]);
      checkOutput("writeRdataKept", g, int'(rdata[g]), 'h5A);
      checkOutput("writeIdleP2", g, int'(p2Pins[g]), 'h81);
    end

    $display("[TB] request held high continuously");
    applyStimulus(1, 0, 1, 16'h0307, 8'h00, 8'h81, 8'h3C, 8'h9E);
    dut0Dones  = 0;
    secondDone = 0;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1, 0, 1, 16'h0307, 8'h00, 8'h81, 8'h3C, 8'h9E);
      @(negedge clk);
      if (done[0]) begin
        dut0Dones++;
        if (dut0Dones == 1) checkOutput("busyFirstDone", 0, c, 5);
        if (dut0Dones == 2) secondDone = c;
      end
      if (c == 6) checkOutput("busyIdleGap", 0, int'(busy[0]), 0);
      if (c == 7) checkOutput("busyReaccept", 0, int'(busy[0]), 1);
    end
    checkOutput("busyDoneCount", 0, dut0Dones, 2);
    checkOutput("busySecondDone", 0, secondDone, 11);
    repeat (30) applyStimulus(0, 0, 1, 16'h0307, 8'h00, 8'h81, 8'h3C, 8'h9E);
    @(negedge clk);
    checkOutput("busyRdata", 0, int'(rdata[0]), 'h9E);

    $display("[TB] async reset during read strobe");
    applyStimulus(1, 0, 1, 16'h4455, 8'h00, 8'h81, 8'h3C, 8'h77);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(0, 0, 1, 16'h4455, 8'h00, 8'h81, 8'h3C, 8'h77);
      @(negedge clk);
    end
    checkOutput("abortPreRdN", 0, int'(rdN[0]), 0);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      checkOutput("abortRdN",   g, int'(rdN[g]),   1);
      checkOutput("abortBusy",  g, int'(busy[g]),  0);
      checkOutput("abortDone",  g, int'(done[g]),  0);
      checkOutput("abortRdata", g, int'(rdata[g]), 'h00);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int g = 0; g < NDUT; g++) doneCnt[g] = 0;
    for (int c = 1; c <= 20; c++) begin
      applyStimulus(0, 0, 1, 16'h4455, 8'h00, 8'h81, 8'h3C, 8'h77);
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) if (done[g]) doneCnt[g]++;
    end
    for (int g = 0; g < NDUT; g++) checkOutput("abortNoDone", g, doneCnt[g], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
